// File: rtl/pspin_pkt_dma_wr_pkg.sv
// pspin_pkt_dma_wr_pkg: AXI response and L2 page constants shared by the packet write engine
package pspin_pkt_dma_wr_pkg;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int PAGE_BITS = 12;
    localparam int PAGE_BYTES = 1 << PAGE_BITS;
endpackage

// File: rtl/pspin_burst_split.sv
// pspin_burst_split: next INCR burst length and follow-on address, capped by burst size and 4 KiB page
module pspin_burst_split
    import pspin_pkt_dma_wr_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BYTES           = 64,
    parameter int BEAT_W          = 15,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BEAT_W-1:0]     beats_left,
    output logic [BEAT_W-1:0]     beats,
    output logic [7:0]            awlen,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    localparam int BW = $clog2(BYTES);
    localparam int PAGE_BEATS = PAGE_BYTES / BYTES;
    logic [BEAT_W-1:0] page_left;
    logic [BEAT_W-1:0] cap;
    always_comb begin
        page_left = BEAT_W'(PAGE_BEATS) - BEAT_W'(addr[PAGE_BITS-1:BW]);
        cap = (page_left < BEAT_W'(MAX_BURST_BEATS)) ? page_left : BEAT_W'(MAX_BURST_BEATS);
        beats = (beats_left < cap) ? beats_left : cap;
        awlen = 8'(beats - BEAT_W'(1));
        next_addr = addr + (ADDR_WIDTH'(beats) << BW);
    end
endmodule

// File: rtl/pspin_pkt_dma_wr.sv
// pspin_pkt_dma_wr: writes one descriptor's packet into L2 as AXI4 INCR bursts and reports completion
module pspin_pkt_dma_wr
    import pspin_pkt_dma_wr_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 32,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_desc_addr,
    input  logic [LEN_WIDTH-1:0]    s_desc_len,
    input  logic [TAG_WIDTH-1:0]    s_desc_tag,
    input  logic                    s_desc_valid,
    output logic                    s_desc_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_done_addr,
    output logic [LEN_WIDTH-1:0]    m_done_len,
    output logic [TAG_WIDTH-1:0]    m_done_tag,
    output logic                    m_done_error,
    output logic                    m_done_valid,
    input  logic                    m_done_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW = $clog2(BYTES);
    localparam int BEAT_W = LEN_WIDTH - BW + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_DRAIN, S_WAIT_B, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [BEAT_W-1:0]     beats_left_q, beats_left_d, burst_left_q, burst_left_d;
    logic                  err_q, err_d, eos_q, eos_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [BEAT_W-1:0]     split_beats;
    logic [ADDR_WIDTH-1:0] split_next;
    logic [BYTES-1:0]      mask;
    logic                  aw_fire, w_fire, b_fire, last_beat, tl;

    pspin_burst_split #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYTES(BYTES),
        .BEAT_W(BEAT_W),
        .MAX_BURST_BEATS(MAX_BURST_BEATS)
    ) u_split (
        .addr(cur_addr_q),
        .beats_left(beats_left_q),
        .beats(split_beats),
        .awlen(m_axi_awlen),
        .next_addr(split_next)
    );

    assign last_beat = beats_left_q == BEAT_W'(1);
    // once the stream has ended early, the remaining beats are padding with no strobes
    assign tl = !eos_q && s_axis_tlast;
    assign mask = (last_beat && len_q[BW-1:0] != '0) ? ~({BYTES{1'b1}} << len_q[BW-1:0]) : '1;

    assign s_desc_ready  = (state_q == S_IDLE) && !rst;
    assign m_axi_bready  = !rst;
    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awvalid = (state_q == S_AW) && (out_q != OUT_W'(MAX_OUTSTANDING));
    assign m_axi_wvalid  = (state_q == S_W) && (eos_q || s_axis_tvalid);
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = (state_q == S_W && !eos_q) ? (s_axis_tkeep & mask) : '0;
    assign m_axi_wlast   = (state_q == S_W) && (burst_left_q == BEAT_W'(1));
    assign s_axis_tready = (state_q == S_W) ? (!eos_q && m_axi_wready) : (state_q == S_DRAIN);
    assign m_done_valid  = state_q == S_DONE;
    assign m_done_addr   = addr_q;
    assign m_done_len    = len_q;
    assign m_done_tag    = tag_q;
    assign m_done_error  = err_q;
    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid && m_axi_wready;
    assign b_fire  = m_axi_bvalid && m_axi_bready;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        len_d = len_q;
        tag_d = tag_q;
        cur_addr_d = cur_addr_q;
        beats_left_d = beats_left_q;
        burst_left_d = burst_left_q;
        err_d = err_q;
        eos_d = eos_q;
        out_d = out_q + OUT_W'(aw_fire) - OUT_W'(b_fire);
        case (state_q)
            S_IDLE: if (s_desc_valid && s_desc_ready) begin
                addr_d = s_desc_addr;
                len_d = s_desc_len;
                tag_d = s_desc_tag;
                cur_addr_d = s_desc_addr;
                beats_left_d = BEAT_W'(({1'b0, s_desc_len} + (LEN_WIDTH + 1)'(BYTES - 1)) >> BW);
                err_d = 1'b0;
                eos_d = 1'b0;
                state_d = (s_desc_len == '0) ? S_DRAIN : S_AW;
            end
            S_AW: if (aw_fire) begin
                burst_left_d = split_beats;
                cur_addr_d = split_next;
                state_d = S_W;
            end
            S_W: if (w_fire) begin
                beats_left_d = beats_left_q - BEAT_W'(1);
                burst_left_d = burst_left_q - BEAT_W'(1);
                if (tl) eos_d = 1'b1;
                if (tl && !last_beat) err_d = 1'b1;
                state_d = last_beat ? ((eos_q || tl) ? S_WAIT_B : S_DRAIN) : (m_axi_wlast ? S_AW : S_W);
            end
            S_DRAIN: if (s_axis_tvalid) begin
                err_d = 1'b1;
                state_d = s_axis_tlast ? S_WAIT_B : S_DRAIN;
            end
            S_WAIT_B: state_d = (out_q == '0) ? S_DONE : S_WAIT_B;
            S_DONE: state_d = m_done_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (b_fire && m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q <= '0;
            len_q <= '0;
            tag_q <= '0;
            cur_addr_q <= '0;
            beats_left_q <= '0;
            burst_left_q <= '0;
            err_q <= 1'b0;
            eos_q <= 1'b0;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            len_q <= len_d;
            tag_q <= tag_d;
            cur_addr_q <= cur_addr_d;
            beats_left_q <= beats_left_d;
            burst_left_q <= burst_left_d;
            err_q <= err_d;
            eos_q <= eos_d;
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_pspin_pkt_dma_wr.sv
// tb_pspin_pkt_dma_wr: randomized bench with a per-beat reference model of bursts, strobes and completions
module tb_pspin_pkt_dma_wr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  s_desc_addr;
    logic [19:0]  s_desc_len;
    logic [31:0]  s_desc_tag;
    logic         s_desc_valid, s_desc_ready;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic         m_axi_awvalid, m_axi_awready;
    logic [511:0] m_axi_wdata;
    logic [63:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid, m_axi_bready;
    logic [31:0]  m_done_addr;
    logic [19:0]  m_done_len;
    logic [31:0]  m_done_tag;
    logic         m_done_error, m_done_valid, m_done_ready;

    pspin_pkt_dma_wr dut (
        .clk(clk), .rst(rst),
        .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_tag(s_desc_tag),
        .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_done_addr(m_done_addr), .m_done_len(m_done_len), .m_done_tag(m_done_tag),
        .m_done_error(m_done_error), .m_done_valid(m_done_valid), .m_done_ready(m_done_ready)
    );

    typedef struct { logic [31:0] addr; logic [19:0] len; logic [31:0] tag; logic err; } desc_t;
    typedef struct { logic [511:0] data; logic [63:0] keep; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [511:0] data; logic [63:0] strb; logic last; } w_t;

    desc_t      desc_q[$], exp_done_q[$];
    beat_t      strm_q[$];
    aw_t        exp_aw_q[$];
    w_t         exp_w_q[$];
    logic [1:0] resp_q[$], aw_resp_q[$], b_resp_q[$];
    int         b_due_q[$];
    int n_pass = 0, n_chk = 0, cyc = 0, out_cnt = 0, max_out = 0;
    int aw_hold = 0, done_hold = 0, w_gap = 10;
    logic b_slow = 1'b0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [511:0] byte_mask(input logic [63:0] s);
        byte_mask = '0;
        for (int j = 0; j < 64; j++) byte_mask[j*8 +: 8] = {8{s[j]}};
    endfunction

    // Model: walk the transfer beat by beat; a burst closes after 16 beats, at a 4 KiB line or at the end.
    task automatic add_job(input logic [31:0] a, input int len, input int ns, input int eb);
        int nb = (len + 63) / 64;
        int r = len % 64;
        int cnt = 0;
        int bi = -1;
        logic [31:0] ba;
        logic [31:0] bstart = '0;
        logic err;
        beat_t s[$];
        beat_t bt;
        w_t w;
        desc_t d;
        err = (ns != nb);
        for (int i = 0; i < ns; i++) begin
            for (int k = 0; k < 16; k++) bt.data[k*32 +: 32] = $urandom;
            bt.keep = {$urandom, $urandom};
            bt.last = (i == ns - 1);
            s.push_back(bt);
            strm_q.push_back(bt);
        end
        for (int i = 0; i < nb; i++) begin
            ba = a + 32'(i * 64);
            if (i == 0 || cnt == 16 || ba[11:0] == 12'h0) begin
                if (i != 0) exp_aw_q.push_back('{bstart, 8'(cnt - 1)});
                bstart = ba;
                cnt = 0;
                bi++;
                resp_q.push_back(bi == eb ? 2'b10 : 2'b00);
                if (bi == eb) err = 1'b1;
            end
            cnt++;
            w.strb = (i < ns) ? s[i].keep : '0;
            if (i == nb - 1 && r != 0) w.strb &= (64'(1) << r) - 64'(1);
            w.data = (i < ns) ? s[i].data : '0;
            w.last = (i == nb - 1) || cnt == 16 || ((ba + 32'd64) & 32'hfff) == 0;
            exp_w_q.push_back(w);
        end
        if (nb != 0) exp_aw_q.push_back('{bstart, 8'(cnt - 1)});
        d = '{a, 20'(len), $urandom, err};
        desc_q.push_back(d);
        exp_done_q.push_back(d);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_done_q.size() != 0 || strm_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("idle_timeout", n >= budget, 0);
        check("aw_left", exp_aw_q.size(), 0);
        check("w_left", exp_w_q.size(), 0);
    endtask

    initial begin
        logic f;
        s_desc_valid = 1'b0; s_desc_addr = '0; s_desc_len = '0; s_desc_tag = '0;
        forever begin
            @(negedge clk);
            f = s_desc_valid && s_desc_ready;
            @(posedge clk); #1;
            if (f) desc_q.delete(0);
            if (f || !s_desc_valid) begin
                s_desc_valid = desc_q.size() > 0 && $urandom_range(0, 3) != 0;
                if (desc_q.size() > 0) begin
                    s_desc_addr = desc_q[0].addr;
                    s_desc_len = desc_q[0].len;
                    s_desc_tag = desc_q[0].tag;
                end
            end
        end
    end

    initial begin
        logic f;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            f = s_axis_tvalid && s_axis_tready;
            @(posedge clk); #1;
            if (f) strm_q.delete(0);
            if (f || !s_axis_tvalid) begin
                s_axis_tvalid = strm_q.size() > 0 && $urandom_range(0, 3) != 0;
                if (strm_q.size() > 0) begin
                    s_axis_tdata = strm_q[0].data;
                    s_axis_tkeep = strm_q[0].keep;
                    s_axis_tlast = strm_q[0].last;
                end
            end
        end
    end

    initial begin
        logic aw_f, w_f, b_f;
        aw_t ea;
        w_t ew;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            aw_f = m_axi_awvalid && m_axi_awready;
            w_f = m_axi_wvalid && m_axi_wready;
            b_f = m_axi_bvalid && m_axi_bready;
            if (aw_f) begin
                if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    ea = exp_aw_q.pop_front();
                    check("awaddr", m_axi_awaddr, ea.addr);
                    check("awlen", m_axi_awlen, ea.len);
                    aw_resp_q.push_back(resp_q.size() > 0 ? resp_q.pop_front() : 2'b00);
                end
            end
            if (w_f) begin
                if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    ew = exp_w_q.pop_front();
                    check("wstrb", m_axi_wstrb, ew.strb);
                    check("wdata", m_axi_wdata & byte_mask(ew.strb), ew.data & byte_mask(ew.strb));
                    check("wlast", m_axi_wlast, ew.last);
                end
                if (m_axi_wlast && aw_resp_q.size() > 0) begin
                    b_resp_q.push_back(aw_resp_q.pop_front());
                    b_due_q.push_back(cyc + (b_slow ? 100 : int'($urandom_range(0, 3))));
                end
            end
            out_cnt += int'(aw_f) - int'(b_f);
            if (out_cnt > max_out) max_out = out_cnt;
            @(posedge clk); #1;
            cyc++;
            if (b_f) begin
                b_resp_q.delete(0);
                b_due_q.delete(0);
            end
            if (aw_hold > 0 && m_axi_awvalid) begin
                m_axi_awready = 1'b0;
                aw_hold--;
            end else m_axi_awready = $urandom_range(0, 3) != 0;
            m_axi_wready = $urandom_range(0, 99) >= w_gap;
            m_axi_bvalid = b_due_q.size() > 0 && b_due_q[0] <= cyc && $urandom_range(0, 1) == 1;
            m_axi_bresp = b_resp_q.size() > 0 ? b_resp_q[0] : 2'b00;
        end
    end

    initial begin
        desc_t e;
        logic held = 1'b0;
        logic [84:0] prev = '0;
        m_done_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_done_valid) begin
                check("desc_stall", s_desc_ready, 0);
                if (held) check("done_stable", {m_done_addr, m_done_len, m_done_tag, m_done_error}, prev);
            end
            if (m_done_valid && m_done_ready) begin
                if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    e = exp_done_q.pop_front();
                    check("done_addr", m_done_addr, e.addr);
                    check("done_len", m_done_len, e.len);
                    check("done_tag", m_done_tag, e.tag);
                    check("done_error", m_done_error, e.err);
                end
            end
            held = m_done_valid && !m_done_ready;
            prev = {m_done_addr, m_done_len, m_done_tag, m_done_error};
            @(posedge clk); #1;
            if (done_hold > 0 && m_done_valid) begin
                m_done_ready = 1'b0;
                done_hold--;
            end else m_done_ready = $urandom_range(0, 2) != 0;
        end
    end

    initial begin
        int len, ns;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_desc_ready", s_desc_ready, 0);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_done_valid", m_done_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_desc_ready", s_desc_ready, 1);
        check("idle_bready", m_axi_bready, 1);

        add_job(32'h1c100000, 1518, 24, -1);
        wait_idle(2000);
        add_job(32'h1c100F80, 512, 8, -1);
        wait_idle(2000);
        add_job(32'h1c100000, 128, 1, -1);
        add_job(32'h1c100400, 64, 3, -1);
        wait_idle(2000);
        add_job(32'h1c100800, 0, 1, -1);
        wait_idle(2000);

        aw_hold = 5;
        done_hold = 10;
        add_job(32'h1c200000, 3072, 48, 1);
        add_job(32'h1c201000, 64, 1, -1);
        wait_idle(4000);

        w_gap = 30;
        for (int i = 0; i < 100; i++) add_job({4'h1, 22'($urandom), 6'h0}, 64, 1, -1);
        wait_idle(20000);

        w_gap = 0;
        b_slow = 1'b1;
        add_job(32'h1c300000, 8192, 128, -1);
        wait_idle(10000);
        b_slow = 1'b0;
        check("max_outstanding", max_out, 4);

        w_gap = 10;
        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(0, 2500);
            ns = (len + 63) / 64 + $urandom_range(0, 2) - 1;
            if (ns < 1) ns = 1;
            add_job({4'h1, 22'($urandom), 6'h0}, len, ns, $urandom_range(0, 9) == 0 ? 0 : -1);
        end
        wait_idle(20000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
